// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_W : width of the operation-select field
//   mode_t : HOLD / SHR / SHL / LOAD operation encoding
package shreg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shreg_fill_ctr.sv
// Saturating fill counter for the shift register.
//   clk     : rising-edge clock
//   clr     : synchronous clear to 0 (highest priority)
//   set_max : jump straight to MAX (parallel load)
//   inc     : count up by one, saturating at MAX
//   fill    : current count, 0..MAX
//   full    : fill == MAX
module shreg_fill_ctr #(
  parameter  int MAX = 8,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set_max,
  input  logic          inc,
  output logic [CW-1:0] fill,
  output logic          full
);

  always_ff @(posedge clk) begin
    if (clr) begin
      fill <= '0;
    end else if (set_max) begin
      fill <= CW'(MAX);
    end else if (inc && !full) begin
      fill <= fill + CW'(1);
    end
  end

  assign full = (fill == CW'(MAX));

endmodule

// File: rtl/shreg_universal.sv
// Parametrised multi-lane universal shift register.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset (clears stages and fill)
//   en      : clock enable, 0 holds all state
//   mode    : HOLD / SHR / SHL / LOAD
//   rot     : on shifts, recirculate the outgoing stage instead of serial input
//   s_in_r  : serial input entering stage DEPTH-1 on SHR
//   s_in_l  : serial input entering stage 0 on SHL
//   p_in    : parallel load data, stage k = p_in[k*WIDTH +: WIDTH]
//   s_out_r : stage 0
//   s_out_l : stage DEPTH-1
//   p_out   : all stages, same packing as p_in
//   fill    : stages written by shifts/loads since reset, 0..DEPTH
//   full    : fill == DEPTH
module shreg_universal
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [MODE_W-1:0]      mode,
  input  logic                   rot,
  input  logic [WIDTH-1:0]       s_in_r,
  input  logic [WIDTH-1:0]       s_in_l,
  input  logic [DEPTH*WIDTH-1:0] p_in,
  output logic [WIDTH-1:0]       s_out_r,
  output logic [WIDTH-1:0]       s_out_l,
  output logic [DEPTH*WIDTH-1:0] p_out,
  output logic [CW-1:0]          fill,
  output logic                   full
);

  logic [DEPTH*WIDTH-1:0] q;
  logic [DEPTH*WIDTH-1:0] q_shr;
  logic [DEPTH*WIDTH-1:0] q_shl;
  logic [WIDTH-1:0]       shr_top;
  logic [WIDTH-1:0]       shl_bot;
  mode_t                  op;

  assign op      = mode_t'(mode);
  // With DEPTH==1 both sources point at the single stage, so rot holds it.
  assign shr_top = rot ? q[0 +: WIDTH] : s_in_r;
  assign shl_bot = rot ? q[(DEPTH-1)*WIDTH +: WIDTH] : s_in_l;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == DEPTH - 1) begin : g_shr_top
      assign q_shr[k*WIDTH +: WIDTH] = shr_top;
    end else begin : g_shr_mid
      assign q_shr[k*WIDTH +: WIDTH] = q[(k+1)*WIDTH +: WIDTH];
    end
    if (k == 0) begin : g_shl_bot
      assign q_shl[k*WIDTH +: WIDTH] = shl_bot;
    end else begin : g_shl_mid
      assign q_shl[k*WIDTH +: WIDTH] = q[(k-1)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      case (op)
        SHR:     q <= q_shr;
        SHL:     q <= q_shl;
        LOAD:    q <= p_in;
        default: q <= q;
      endcase
    end
  end

  // Fill only tracks new data arriving: rotation merely reorders stages.
  shreg_fill_ctr #(.MAX(DEPTH)) u_fill (
    .clk     (clk),
    .clr     (reset),
    .set_max (en && (op == LOAD)),
    .inc     (en && !rot && ((op == SHR) || (op == SHL))),
    .fill    (fill),
    .full    (full)
  );

  assign p_out   = q;
  assign s_out_r = q[0 +: WIDTH];
  assign s_out_l = q[(DEPTH-1)*WIDTH +: WIDTH];

endmodule
